// File: rtl/sym_dn_lut_pipe.sv
// Symmetric decision-node LUT readout: PORT_NUM folded read channels, 3-stage stallable pipeline,
// two-set 1-bit LUT loaded by a streaming FSM. Define SYM_DN_LUT_WR_FWD_EN to forward same-cycle load writes to S1 reads.
module sym_dn_lut_pipe #(
   parameter int  PORT_NUM  = 4,
   parameter int  QUAN_SIZE = 4,
   localparam int IDX_W     = 2*QUAN_SIZE-1,
   localparam int SET_NUM   = 2
) (
   input  logic                          read_clk,
   input  logic                          rstn,
   input  logic                          pipe_en,
   input  logic [PORT_NUM-1:0]           in_valid,
   input  logic [PORT_NUM-1:0]           transpose_en,
   input  logic [PORT_NUM*QUAN_SIZE-1:0] y0_in,
   input  logic [PORT_NUM*QUAN_SIZE-1:0] y1_in,
   input  logic                          read_addr_offset,
   output logic [PORT_NUM-1:0]           t_c,
   output logic [PORT_NUM-1:0]           t_c_valid,
   input  logic                          lut_load_start,
   input  logic                          lut_load_offset,
   input  logic                          lut_load_data,
   input  logic                          lut_load_valid,
   output logic                          lut_load_busy,
   output logic                          lut_load_done
);
   localparam int DEPTH = 1 << IDX_W;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} load_state_e;

   load_state_e          state_q, state_d;
   logic [IDX_W-1:0]     cnt_q, cnt_d;
   logic                 set_q, set_d;
   logic                 wr_en;
   logic [DEPTH-1:0]     lut_q [SET_NUM];
   logic [DEPTH-1:0]     lut_d [SET_NUM];

   logic [IDX_W-1:0]     idx0_q [PORT_NUM];
   logic [IDX_W-1:0]     idx0_d [PORT_NUM];
   logic [PORT_NUM-1:0]  m0_q, m0_d, v0_q, v0_d;
   logic                 off0_q, off0_d;
   logic [PORT_NUM-1:0]  d1_q, d1_d, m1_q, m1_d, v1_q, v1_d;
   logic [PORT_NUM-1:0]  t_c_q, t_c_d, t_c_valid_q, t_c_valid_d;

   logic [QUAN_SIZE-1:0] y0_k, y1_k;
   logic                 s_k, m_k;

   // S0: symmetry fold of each channel into a LUT index plus sign-restore bit
   always_comb begin
      idx0_d = idx0_q;
      m0_d   = m0_q;
      v0_d   = v0_q;
      off0_d = off0_q;
      y0_k   = '0;
      y1_k   = '0;
      s_k    = 1'b0;
      m_k    = 1'b0;
      if (pipe_en) begin
         off0_d = read_addr_offset;
         v0_d   = in_valid;
         for (int unsigned k = 0; k < PORT_NUM; k++) begin
            y0_k      = y0_in[k*QUAN_SIZE +: QUAN_SIZE];
            y1_k      = y1_in[k*QUAN_SIZE +: QUAN_SIZE];
            s_k       = y0_k[QUAN_SIZE-1];
            m_k       = transpose_en[k] ^ s_k;
            m0_d[k]   = m_k;
            idx0_d[k] = {y0_k[QUAN_SIZE-2:0] ^ {(QUAN_SIZE-1){s_k}}, m_k ? ~y1_k : y1_k};
         end
      end
   end

   // S1 reads the stored array, i.e. the value before any write landing on the same edge
   always_comb begin
      d1_d = d1_q;
      m1_d = m1_q;
      v1_d = v1_q;
      if (pipe_en) begin
         m1_d = m0_q;
         v1_d = v0_q;
         for (int unsigned k = 0; k < PORT_NUM; k++) begin
            d1_d[k] = lut_q[off0_q][idx0_q[k]];
`ifdef SYM_DN_LUT_WR_FWD_EN
            if (wr_en && (set_q == off0_q) && (cnt_q == idx0_q[k])) begin
               d1_d[k] = lut_load_data;
            end
`endif
         end
      end
   end

   always_comb begin
      t_c_d       = t_c_q;
      t_c_valid_d = t_c_valid_q;
      if (pipe_en) begin
         t_c_d       = d1_q ^ m1_q;
         t_c_valid_d = v1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      set_d   = set_q;
      lut_d   = lut_q;
      wr_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (lut_load_start) begin
               state_d = LOAD;
               cnt_d   = '0;
               set_d   = lut_load_offset;
            end
         end
         LOAD: begin
            if (lut_load_valid) begin
               wr_en = rstn;
               cnt_d = cnt_q + 1'b1;
               if (&cnt_q) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (wr_en) lut_d[set_q][cnt_q] = lut_load_data;
   end

   // LUT storage deliberately survives reset
   always_ff @(posedge read_clk) begin
      lut_q <= lut_d;
   end

   always_ff @(posedge read_clk) begin
      if (!rstn) begin
         for (int unsigned k = 0; k < PORT_NUM; k++) idx0_q[k] <= '0;
         m0_q        <= '0;
         v0_q        <= '0;
         off0_q      <= 1'b0;
         d1_q        <= '0;
         m1_q        <= '0;
         v1_q        <= '0;
         t_c_q       <= '0;
         t_c_valid_q <= '0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         set_q       <= 1'b0;
      end else begin
         idx0_q      <= idx0_d;
         m0_q        <= m0_d;
         v0_q        <= v0_d;
         off0_q      <= off0_d;
         d1_q        <= d1_d;
         m1_q        <= m1_d;
         v1_q        <= v1_d;
         t_c_q       <= t_c_d;
         t_c_valid_q <= t_c_valid_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         set_q       <= set_d;
      end
   end

   assign t_c           = t_c_q;
   assign t_c_valid     = t_c_valid_q;
   assign lut_load_busy = (state_q == LOAD);
   assign lut_load_done = (state_q == DONE);

endmodule

// File: tb/tb_sym_dn_lut_pipe.sv
// Self-checking bench for sym_dn_lut_pipe: transaction-level reference model plus directed and random traffic.
module tb_sym_dn_lut_pipe;
   localparam int P = 4;
   localparam int Q = 4;
`ifdef SYM_DN_LUT_WR_FWD_EN
   localparam logic COLLIDE_EXP = 1'b1;
`else
   localparam logic COLLIDE_EXP = 1'b0;
`endif

   logic           read_clk = 1'b0;
   logic           rstn, pipe_en, read_addr_offset;
   logic [P-1:0]   in_valid, transpose_en, t_c, t_c_valid;
   logic [P*Q-1:0] y0_in, y1_in;
   logic           lut_load_start, lut_load_offset, lut_load_data, lut_load_valid;
   logic           lut_load_busy, lut_load_done;

   sym_dn_lut_pipe #(.PORT_NUM(P), .QUAN_SIZE(Q)) dut (
      .read_clk(read_clk), .rstn(rstn), .pipe_en(pipe_en), .in_valid(in_valid),
      .transpose_en(transpose_en), .y0_in(y0_in), .y1_in(y1_in),
      .read_addr_offset(read_addr_offset), .t_c(t_c), .t_c_valid(t_c_valid),
      .lut_load_start(lut_load_start), .lut_load_offset(lut_load_offset),
      .lut_load_data(lut_load_data), .lut_load_valid(lut_load_valid),
      .lut_load_busy(lut_load_busy), .lut_load_done(lut_load_done)
   );

   always #5 read_clk = ~read_clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: fold by arithmetic reflection (x xor all-ones == max - x)
   function automatic logic [7:0] fold(input logic [3:0] y0, input logic [3:0] y1, input logic te);
      int   a, b;
      logic s, mm;
      s  = y0[3];
      a  = s ? 7 - int'(y0[2:0]) : int'(y0[2:0]);
      mm = te ^ s;
      b  = mm ? 15 - int'(y1) : int'(y1);
      return {mm, 7'(a*16 + b)};
   endfunction

   typedef struct {
      logic [P*7-1:0] idx;
      logic [P-1:0]   m, v, d, kn;
      logic           off;
      int             age;
   } tx_t;

   tx_t        q[$];
   bit         mlut   [2][128];
   bit         mknown [2][128];
   logic [P-1:0] exp_tc = '0, exp_v = '0, exp_kn = '0;
   logic       exp_busy = 1'b0, exp_done = 1'b0;
   bit         m_loading = 1'b0, m_set = 1'b0, prev_done;
   int         m_cnt = 0;

   always @(posedge read_clk) begin
      if (!rstn) begin
         q.delete();
         exp_tc = '0; exp_v = '0; exp_kn = '0;
         m_loading = 1'b0; m_cnt = 0; exp_done = 1'b0; exp_busy = 1'b0;
      end else begin
         bit   wr;
         int   wa;
         bit   ws, wd;
         tx_t  t;
         logic [7:0] f;
         wr = m_loading && lut_load_valid;
         wa = m_cnt; ws = m_set; wd = lut_load_data;
`ifdef SYM_DN_LUT_WR_FWD_EN
         if (wr) begin mlut[ws][wa] = wd; mknown[ws][wa] = 1'b1; end
`endif
         if (pipe_en) begin
            for (int i = 0; i < q.size(); i++) begin
               t = q[i];
               t.age++;
               if (t.age == 1) begin
                  for (int k = 0; k < P; k++) begin
                     t.d[k]  = mlut[t.off][t.idx[k*7 +: 7]];
                     t.kn[k] = mknown[t.off][t.idx[k*7 +: 7]];
                  end
               end
               q[i] = t;
            end
            if (q.size() > 0 && q[0].age == 2) begin
               t = q.pop_front();
               exp_v  = t.v;
               exp_tc = t.d ^ t.m;
               exp_kn = t.kn;
            end
            t.age = 0; t.v = in_valid; t.off = read_addr_offset; t.d = '0; t.kn = '0;
            for (int k = 0; k < P; k++) begin
               f = fold(y0_in[k*Q +: Q], y1_in[k*Q +: Q], transpose_en[k]);
               t.idx[k*7 +: 7] = f[6:0];
               t.m[k] = f[7];
            end
            q.push_back(t);
         end
`ifndef SYM_DN_LUT_WR_FWD_EN
         if (wr) begin mlut[ws][wa] = wd; mknown[ws][wa] = 1'b1; end
`endif
         prev_done = exp_done;
         exp_done  = 1'b0;
         if (m_loading) begin
            if (lut_load_valid) begin
               if (m_cnt == 127) begin m_loading = 1'b0; exp_done = 1'b1; end
               m_cnt++;
            end
         end else if (!prev_done && lut_load_start) begin
            m_loading = 1'b1; m_cnt = 0; m_set = lut_load_offset;
         end
         exp_busy = m_loading;
      end
   end

   always @(negedge read_clk) begin
      if (chk_en) begin
         chk("t_c_valid", 32'(t_c_valid), 32'(exp_v));
         chk("busy", 32'(lut_load_busy), 32'(exp_busy));
         chk("done", 32'(lut_load_done), 32'(exp_done));
         for (int k = 0; k < P; k++)
            if (exp_v[k] && exp_kn[k]) chk($sformatf("t_c[%0d]", k), 32'(t_c[k]), 32'(exp_tc[k]));
      end
   end

   task automatic cyc();
      @(negedge read_clk);
   endtask

   function automatic logic beat(input int mode, input int i);
      case (mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return i[0];
         3:       return (i == 5);
         default: return ~i[0];
      endcase
   endfunction

   task automatic load_set(input bit set, input int mode, input int gaps, input bit restart);
      int g = 0, busy_low = 0, dones = 0;
      lut_load_offset = set; lut_load_start = 1'b1; cyc(); lut_load_start = 1'b0;
      if (!lut_load_busy) busy_low++;
      for (int i = 0; i < 128; i++) begin
         if (g < gaps && (i % 12) == 3) begin
            lut_load_valid = 1'b0;
            if (restart && g == 0) begin lut_load_start = 1'b1; lut_load_offset = ~set; end
            cyc();
            lut_load_start = 1'b0; lut_load_offset = set; g++;
            if (!lut_load_busy) busy_low++;
            if (lut_load_done) dones++;
         end
         lut_load_valid = 1'b1; lut_load_data = beat(mode, i); cyc();
         if (i < 127) begin
            if (!lut_load_busy) busy_low++;
            if (lut_load_done) dones++;
         end
      end
      lut_load_valid = 1'b0;
      chk("done_after_last", 32'(lut_load_done), 32'd1);
      chk("busy_after_last", 32'(lut_load_busy), 32'd0);
      cyc();
      chk("done_single_pulse", 32'(lut_load_done), 32'd0);
      chk("busy_during_load", 32'(busy_low), 32'd0);
      chk("early_done", 32'(dones), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] seq;
      rstn = 1'b0; pipe_en = 1'b1; in_valid = '0; transpose_en = '0; y0_in = '0; y1_in = '0;
      read_addr_offset = 1'b0; lut_load_start = 1'b0; lut_load_offset = 1'b0;
      lut_load_data = 1'b0; lut_load_valid = 1'b0;
      cyc(); cyc();
      rstn = 1'b1;
      chk("rst_t_c", 32'(t_c), 32'd0);
      chk("rst_t_c_valid", 32'(t_c_valid), 32'd0);
      chk("rst_busy", 32'(lut_load_busy), 32'd0);
      chk("rst_done", 32'(lut_load_done), 32'd0);
      chk("model_fold", 32'(fold(4'b1010, 4'b0011, 1'b0)), 32'({1'b1, 7'd92}));
      chk("model_fold_t", 32'(fold(4'b1010, 4'b0011, 1'b1)), 32'({1'b0, 7'd83}));
      chk_en = 1'b1;

      // 1: fold on set 0 (all zero)
      load_set(1'b0, 0, 0, 1'b0);
      for (int r = 0; r < 2; r++) begin
         y0_in[3:0] = 4'b1010; y1_in[3:0] = 4'b0011; transpose_en = 4'(r);
         in_valid = 4'b0001; read_addr_offset = 1'b0;
         cyc(); in_valid = '0; cyc();
         chk("t1_not_yet", 32'(t_c_valid[0]), 32'd0);
         cyc();
         chk("t1_valid", 32'(t_c_valid[0]), 32'd1);
         chk("t1_t_c", 32'(t_c[0]), (r == 0) ? 32'd1 : 32'd0);
         cyc();
         chk("t1_no_dup", 32'(t_c_valid[0]), 32'd0);
      end
      transpose_en = '0;

      // 2: load with gaps and an ignored restart
      load_set(1'b1, 2, 10, 1'b1);

      // 3: all channels, two stall cycles mid-flight
      y0_in = {4'b0101, 4'b1111, 4'b0011, 4'b1000};
      y1_in = {4'b0110, 4'b1001, 4'b0111, 4'b0010};
      transpose_en = 4'b1100; in_valid = 4'hF; read_addr_offset = 1'b0;
      cyc(); in_valid = '0; transpose_en = '0; cyc();
      pipe_en = 1'b0; cyc(); cyc();
      chk("t3_stalled", 32'(t_c_valid), 32'd0);
      pipe_en = 1'b1; cyc();
      chk("t3_valid", 32'(t_c_valid), 32'hF);
      chk("t3_t_c", 32'(t_c), 32'b1001);
      cyc();
      chk("t3_no_dup", 32'(t_c_valid), 32'd0);

      // 4: offset ping-pong, set 1 all ones
      load_set(1'b1, 1, 0, 1'b0);
      y0_in = '0; y1_in = '0; y0_in[11:8] = 4'b0001; seq = '0;
      for (int i = 0; i < 6; i++) begin
         in_valid = (i < 4) ? 4'b0100 : 4'b0000;
         read_addr_offset = i[0];
         cyc();
         if (i >= 2) begin
            chk("t4_valid", 32'(t_c_valid[2]), 32'd1);
            seq[i-2] = t_c[2];
         end
      end
      chk("t4_pingpong", 32'(seq), 32'b1010);
      in_valid = '0; read_addr_offset = 1'b0;

      // 5: S1 read of set 0 idx 5 on the edge the load writes idx 5
      y0_in = '0; y1_in = '0; y1_in[7:4] = 4'b0101;
      lut_load_offset = 1'b0; lut_load_start = 1'b1; cyc(); lut_load_start = 1'b0;
      for (int i = 0; i < 128; i++) begin
         lut_load_valid = 1'b1; lut_load_data = beat(3, i);
         in_valid = (i == 4) ? 4'b0010 : 4'b0000;
         cyc();
         if (i == 6) begin
            chk("t5_valid", 32'(t_c_valid[1]), 32'd1);
            chk("t5_collision", 32'(t_c[1]), 32'(COLLIDE_EXP));
         end
      end
      lut_load_valid = 1'b0; cyc(); cyc();

      // 6: reset after 40 beats, then full reload
      lut_load_offset = 1'b1; lut_load_start = 1'b1; cyc(); lut_load_start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         lut_load_valid = 1'b1; lut_load_data = beat(4, i);
         in_valid = 4'($urandom()); y0_in = 16'($urandom()); y1_in = 16'($urandom());
         read_addr_offset = 1'b0;
         cyc();
      end
      lut_load_valid = 1'b0; in_valid = '0; rstn = 1'b0; cyc();
      chk("t6_busy", 32'(lut_load_busy), 32'd0);
      chk("t6_done", 32'(lut_load_done), 32'd0);
      chk("t6_t_c", 32'(t_c), 32'd0);
      chk("t6_t_c_valid", 32'(t_c_valid), 32'd0);
      rstn = 1'b1;
      load_set(1'b1, 4, 0, 1'b0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rstn             = ($urandom_range(0, 599) != 0);
         pipe_en          = ($urandom_range(0, 3) != 0);
         in_valid         = 4'($urandom());
         transpose_en     = 4'($urandom());
         y0_in            = 16'($urandom());
         y1_in            = 16'($urandom());
         read_addr_offset = 1'($urandom());
         lut_load_start   = ($urandom_range(0, 40) == 0);
         lut_load_offset  = 1'($urandom());
         lut_load_valid   = ($urandom_range(0, 3) != 0);
         lut_load_data    = 1'($urandom());
         cyc();
      end
      rstn = 1'b1; pipe_en = 1'b1; in_valid = '0; lut_load_start = 1'b0; lut_load_valid = 1'b0;
      repeat (4) cyc();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
